// File: rtl/nand_phy_wr_dqs_seq_if.sv
// Bundle between the NAND write-path sequencer, its request source, the write-data FIFO
// and the DQS/DQ IOB stage. The master side is the controller/FIFO/IOB environment.
interface nand_phy_wr_dqs_seq_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 wr_req;
  logic [LEN_WIDTH-1:0] wr_len;
  logic                 wr_ack;
  logic                 wr_done;
  logic                 busy;
  logic                 stall;
  logic [15:0]          fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 dqs_oe_n;
  logic                 dqs_rst_n;
  logic                 dq_oe_n;
  logic [7:0]           dq_rise;
  logic [7:0]           dq_fall;

  modport master (
    output wr_req, wr_len, fifo_dout, fifo_empty,
    input  wr_ack, wr_done, busy, stall, fifo_rd_en,
           dqs_oe_n, dqs_rst_n, dq_oe_n, dq_rise, dq_fall
  );

  modport slave (
    input  wr_req, wr_len, fifo_dout, fifo_empty,
    output wr_ack, wr_done, busy, stall, fifo_rd_en,
           dqs_oe_n, dqs_rst_n, dq_oe_n, dq_rise, dq_fall
  );
endinterface

// File: rtl/nand_phy_wr_dqs_seq.sv
// NV-DDR data-in write sequencer: frames each burst as DQS preamble, data beats and
// postamble, pulling 16-bit words from the write FIFO and feeding the DQS/DQ IOBs.
module nand_phy_wr_dqs_seq #(
  parameter int PRE_CYCLES  = 2,
  parameter int POST_CYCLES = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk0,
  input  logic                  rst0,
  nand_phy_wr_dqs_seq_if.slave  bus
);

  localparam int PW = $clog2(PRE_CYCLES + 1);
  localparam int QW = $clog2(POST_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_POST} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] rem;        // words still to be popped
  logic [LEN_WIDTH-1:0] rem_after;
  logic [PW-1:0]        pre_cnt;    // PRE cycles left, including the current one
  logic [QW-1:0]        post_cnt;
  logic                 dout_vld;   // fifo_dout carries a popped word this cycle
  logic                 pop_ok;

  // A pop is issued for the next cycle from this cycle's empty flag, so the FIFO
  // must raise fifo_empty one word early (almost-empty behaviour).
  assign rem_after = rem - LEN_WIDTH'(bus.fifo_rd_en);
  assign pop_ok    = (rem_after != '0) && !bus.fifo_empty;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state          <= ST_IDLE;
      rem            <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      dout_vld       <= 1'b0;
      bus.wr_ack     <= 1'b0;
      bus.wr_done    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.stall      <= 1'b0;
      bus.fifo_rd_en <= 1'b0;
      bus.dqs_oe_n   <= 1'b1;
      bus.dq_oe_n    <= 1'b1;
      bus.dqs_rst_n  <= 1'b0;
      bus.dq_rise    <= '0;
      bus.dq_fall    <= '0;
    end else begin
      // NOTE: pulse/default values first, overridden below; with non-blocking
      // assignments the last one in program order wins, so no latch or race results.
      bus.wr_ack     <= 1'b0;
      bus.wr_done    <= 1'b0;
      bus.stall      <= 1'b0;
      bus.fifo_rd_en <= 1'b0;
      bus.dqs_rst_n  <= 1'b0;
      dout_vld       <= bus.fifo_rd_en;

      if (dout_vld) begin
        bus.dqs_rst_n <= 1'b1;
        bus.dq_rise   <= bus.fifo_dout[7:0];
        bus.dq_fall   <= bus.fifo_dout[15:8];
      end

      case (state)
        ST_IDLE: begin
          if (bus.wr_req) begin
            bus.wr_ack <= 1'b1;
            if (bus.wr_len == '0) begin
              bus.wr_done <= 1'b1;
            end else begin
              state          <= ST_PRE;
              rem            <= bus.wr_len;
              pre_cnt        <= PW'(PRE_CYCLES);
              bus.busy       <= 1'b1;
              bus.dqs_oe_n   <= 1'b0;
              bus.dq_oe_n    <= 1'b0;
              bus.dq_rise    <= '0;
              bus.dq_fall    <= '0;
              bus.fifo_rd_en <= (PRE_CYCLES <= 2) && !bus.fifo_empty;
            end
          end
        end

        ST_PRE: begin
          rem            <= rem_after;
          // Prefetch window covers the last two PRE cycles.
          bus.fifo_rd_en <= (pre_cnt <= PW'(3)) && pop_ok;
          if (pre_cnt == PW'(1)) begin
            state     <= ST_DATA;
            bus.stall <= !dout_vld;
          end else begin
            pre_cnt <= pre_cnt - PW'(1);
          end
        end

        ST_DATA: begin
          rem            <= rem_after;
          bus.fifo_rd_en <= pop_ok;
          if (rem == '0 && !dout_vld) begin
            state    <= ST_POST;
            post_cnt <= QW'(POST_CYCLES);
          end else begin
            bus.stall <= !dout_vld;
          end
        end

        ST_POST: begin
          if (post_cnt == QW'(1)) begin
            state        <= ST_IDLE;
            bus.wr_done  <= 1'b1;
            bus.busy     <= 1'b0;
            bus.dqs_oe_n <= 1'b1;
            bus.dq_oe_n  <= 1'b1;
            bus.dq_rise  <= '0;
            bus.dq_fall  <= '0;
          end else begin
            post_cnt <= post_cnt - QW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
